// File: rtl/audio_ser_tx.sv
// Serial audio transmitter: left-justified 3-wire link (SCLK, LRCLK, SDout).
// Takes one left/right sample pair per frame through a one-entry holding
// register and shifts it out MSB-first. Data changes on SCLK falling edges
// and is sampled by the codec on rising edges. Bit and word clocks are
// derived from clk.
module audio_ser_tx #(
    parameter int DATA_W   = 16,  // bits per channel sample (>= 2)
    parameter int SCLK_DIV = 4    // clk cycles per SCLK half-period (>= 2)
) (
    input  logic              clk,
    input  logic              CLRN,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
    input  logic              vld_in,
    output logic              rdy_out,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              SDout,
    output logic              underrun
);

    localparam int FRAME_BITS = 2 * DATA_W;
    localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(DATA_W);

    // Clock generation state
    logic [DIV_W-1:0]      div_cnt;
    logic                  sclk_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  lrclk_q;

    // Data path state
    logic [FRAME_BITS-1:0] shreg;
    logic [DATA_W-1:0]     hold_l;
    logic [DATA_W-1:0]     hold_r;
    logic                  hold_full;
    logic                  underrun_q;

    // Per-cycle events
    logic                  tick;
    logic                  fall;
    logic                  frame_start;
    logic                  capture;
    logic [BIT_W-1:0]      bit_nxt;

    // Decode divider wrap, SCLK fall, frame start and the next bit index.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tick        = 1'b0;
        fall        = 1'b0;
        frame_start = 1'b0;
        capture     = 1'b0;
        bit_nxt     = '0;

        tick        = (div_cnt == DIV_LAST);
        fall        = tick & sclk_q;
        frame_start = fall & (bit_cnt == BIT_LAST);
        capture     = vld_in & ~hold_full;
        bit_nxt     = frame_start ? '0 : bit_cnt + 1'b1;
    end

    // Divider: wrap every SCLK_DIV clocks and toggle SCLK on the wrap.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!CLRN) begin
            div_cnt <= '0;
            sclk_q  <= 1'b1;
        end else if (tick) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Bit counter and word select advance together on each SCLK fall.
    always_ff @(posedge clk) begin
        if (!CLRN) begin
            bit_cnt <= BIT_LAST;
            lrclk_q <= 1'b1;
        end else if (fall) begin
            bit_cnt <= bit_nxt;
            lrclk_q <= (bit_nxt >= BIT_RIGHT);
        end
    end

    // Shift register: load a whole frame at frame start, otherwise shift
    // one bit per fall. An empty holding register sends a silent frame.
    always_ff @(posedge clk) begin
        if (!CLRN) begin
            shreg <= '0;
        end else if (frame_start) begin
            shreg <= hold_full ? {hold_l, hold_r} : '0;
        end else if (fall) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
    end

    // Underrun flag: a one-clk pulse coincident with the silent frame start.
    always_ff @(posedge clk) begin
        if (!CLRN) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= frame_start & ~hold_full;
        end
    end

    // Holding register: capture when empty, release on frame load. A capture
    // and a frame start in the same clk only happen when empty, so the
    // frame takes zeros and the new pair waits for the next frame.
    // NOTE: the data words are reset too, so an aborted frame can never
    // leak stale samples into the link after reset.
    always_ff @(posedge clk) begin
        if (!CLRN) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (capture) begin
            hold_full <= 1'b1;
            hold_l    <= lft_in;
            hold_r    <= rht_in;
        end else if (frame_start) begin
            hold_full <= 1'b0;
        end
    end

    assign rdy_out  = ~hold_full;
    assign SCLK     = sclk_q;
    assign LRCLK    = lrclk_q;
    assign SDout    = shreg[FRAME_BITS-1];
    assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_ser_tx.sv
// Directed bench for audio_ser_tx: a link monitor decodes SDout on SCLK
// rises into frames; the main sequence drives reset, single, streaming,
// underrun, same-clk and mid-frame-reset scenarios against hand-computed
// frame contents and cycle positions.
module tb_audio_ser_tx;

    localparam int DATA_W   = 16;
    localparam int SCLK_DIV = 4;
    localparam int FRAME_CLK = 2 * DATA_W * 2 * SCLK_DIV;  // 256

    logic              clk = 1'b0;
    logic              CLRN;
    logic [DATA_W-1:0] lft_in;
    logic [DATA_W-1:0] rht_in;
    logic              vld_in;
    logic              rdy_out;
    logic              SCLK;
    logic              LRCLK;
    logic              SDout;
    logic              underrun;

    audio_ser_tx #(.DATA_W(DATA_W), .SCLK_DIV(SCLK_DIV)) dut (
        .clk      (clk),
        .CLRN     (CLRN),
        .lft_in   (lft_in),
        .rht_in   (rht_in),
        .vld_in   (vld_in),
        .rdy_out  (rdy_out),
        .SCLK     (SCLK),
        .LRCLK    (LRCLK),
        .SDout    (SDout),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Counts rising clk edges since time zero.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Link monitor: frame begins on LRCLK 1->0, bits are taken on SCLK rises.
    logic [31:0] frames[$];
    bit          frame_lr[$];
    logic        frame_ur[$];
    int          starts[$];
    int          ur_cycles = 0;
    logic        prev_lr   = 1'b1;
    logic        prev_sclk = 1'b1;
    bit          collecting = 1'b0;
    bit          lr_ok = 1'b1;
    int          nbits = 0;
    logic [31:0] word = '0;

    always @(negedge clk) begin
        if (CLRN !== 1'b1) begin
            collecting = 1'b0;
            nbits      = 0;
        end else begin
            if (prev_lr === 1'b1 && LRCLK === 1'b0) begin
                starts.push_back(cyc);
                frame_ur.push_back(underrun);
                collecting = 1'b1;
                nbits      = 0;
                word       = '0;
                lr_ok      = 1'b1;
            end
            if (prev_sclk === 1'b0 && SCLK === 1'b1 && collecting) begin
                word = {word[30:0], SDout};
                if (LRCLK !== (nbits >= DATA_W)) lr_ok = 1'b0;
                nbits++;
                if (nbits == 2 * DATA_W) begin
                    frames.push_back(word);
                    frame_lr.push_back(lr_ok);
                    collecting = 1'b0;
                end
            end
            if (underrun === 1'b1) ur_cycles++;
        end
        prev_lr   = LRCLK;
        prev_sclk = SCLK;
    end

    // Advance to just after the next falling clk edge (monitor already updated).
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (rdy_out !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        check("wait_rdy", rdy_out, 1'b1);
    endtask

    task automatic wait_starts(input int want);
        int n = 0;
        while (starts.size() < want && n < 1200) begin
            step();
            n++;
        end
        check("wait_frame_start", 32'(starts.size() >= want), 32'd1);
    endtask

    task automatic wait_frames(input int want);
        int n = 0;
        while (frames.size() < want && n < 1200) begin
            step();
            n++;
        end
        check("wait_frame_done", 32'(frames.size() >= want), 32'd1);
    endtask

    task automatic offer(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        vld_in = 1'b1;
        lft_in = l;
        rht_in = r;
        step();
        vld_in = 1'b0;
    endtask

    logic [DATA_W-1:0] stream_l [3] = '{16'h0001, 16'h7FFF, 16'h1234};
    logic [DATA_W-1:0] stream_r [3] = '{16'h8000, 16'hFFFF, 16'hFEDC};

    logic [31:0] exp_frames [9] = '{
        32'hA5C3_3C5A, 32'h0001_8000, 32'h7FFF_FFFF, 32'h1234_FEDC, 32'h0000_0000,
        32'h5555_AAAA, 32'h0000_0000, 32'h0F0F_F0F0, 32'h6789_9876
    };
    logic exp_ur [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int first_fall;
        int target;
        int s8;

        CLRN   = 1'b0;
        vld_in = 1'b0;
        lft_in = '0;
        rht_in = '0;

        // Reset held for 3 clk
        repeat (3) step();
        check("rst_sclk",     SCLK,     1'b1);
        check("rst_lrclk",    LRCLK,    1'b1);
        check("rst_sdout",    SDout,    1'b0);
        check("rst_rdy",      rdy_out,  1'b1);
        check("rst_underrun", underrun, 1'b0);

        // Release and offer the single pair before the first frame start
        CLRN   = 1'b1;
        vld_in = 1'b1;
        lft_in = 16'hA5C3;
        rht_in = 16'h3C5A;
        first_fall = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                check("single_rdy_low", rdy_out, 1'b0);
                vld_in = 1'b0;
            end
            if (k == 3) check("single_rdy_before_load", rdy_out, 1'b0);
            if (SCLK === 1'b0) begin
                first_fall = k;
                break;
            end
        end
        check("first_fall_clk",        first_fall, 32'd4);
        check("single_rdy_after_load", rdy_out,    1'b1);
        check("first_lrclk_left",      LRCLK,      1'b0);
        check("first_sdout_msb",       SDout,      1'b1);
        check("first_no_underrun",     underrun,   1'b0);

        // Streaming: offer whenever the holding register is empty
        for (int i = 0; i < 3; i++) begin
            wait_rdy();
            offer(stream_l[i], stream_r[i]);
        end

        // Frame 4 starts with nothing held; then refill for frame 5
        wait_starts(5);
        wait_rdy();
        offer(16'h5555, 16'hAAAA);

        // vld_in in the exact clk of frame 6 start, holding empty
        wait_starts(6);
        target = starts[5] + FRAME_CLK;
        while (cyc < target - 1) step();
        vld_in = 1'b1;
        lft_in = 16'h0F0F;
        rht_in = 16'hF0F0;
        step();
        vld_in = 1'b0;
        check("sim_underrun",   underrun, 1'b1);
        check("sim_captured",   rdy_out,  1'b0);
        check("sim_lrclk_left", LRCLK,    1'b0);

        // Held pair loads at frame 7 start; rdy_out rises the next clk
        while (cyc < target + FRAME_CLK - 1) step();
        check("held_rdy_before", rdy_out, 1'b0);
        step();
        check("held_rdy_after",   rdy_out,  1'b1);
        check("held_no_underrun", underrun, 1'b0);

        // Frame 8 carries all ones; a further pair waits in holding
        offer(16'hFFFF, 16'hFFFF);
        wait_starts(9);
        wait_rdy();
        offer(16'h1111, 16'h2222);

        // Reset in the clk where bit_cnt = 10 of frame 8, SCLK low
        s8 = starts[8];
        while (cyc < s8 + 81) step();
        check("pre_rst_sdout", SDout,   1'b1);
        check("pre_rst_lrclk", LRCLK,   1'b0);
        check("pre_rst_sclk",  SCLK,    1'b0);
        check("pre_rst_rdy",   rdy_out, 1'b0);
        CLRN = 1'b0;
        step();
        check("mid_rst_sclk",     SCLK,     1'b1);
        check("mid_rst_lrclk",    LRCLK,    1'b1);
        check("mid_rst_sdout",    SDout,    1'b0);
        check("mid_rst_rdy",      rdy_out,  1'b1);
        check("mid_rst_underrun", underrun, 1'b0);
        step();
        CLRN = 1'b1;
        offer(16'h6789, 16'h9876);
        check("post_rst_capture", rdy_out, 1'b0);
        wait_frames(9);
        wait_starts(10);

        // Decoded frame contents and word-select alignment
        for (int k = 0; k < 9; k++) begin
            if (k < frames.size()) begin
                check($sformatf("frame%0d_data", k), frames[k], exp_frames[k]);
                check($sformatf("frame%0d_lrclk", k), 32'(frame_lr[k]), 32'd1);
            end
        end
        // Underrun flag seen at each frame start
        for (int k = 0; k < 10; k++) begin
            if (k < frame_ur.size())
                check($sformatf("start%0d_underrun", k), frame_ur[k], exp_ur[k]);
        end
        // Frame spacing before the mid-frame reset
        for (int k = 0; k < 8; k++) begin
            if (k + 1 < starts.size())
                check($sformatf("frame%0d_len", k), 32'(starts[k+1] - starts[k]), 32'(FRAME_CLK));
        end
        check("underrun_total_clks", 32'(ur_cycles), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sequence did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
